// File: rtl/dft_pkg.sv
// Shared types and default sizes for the sliding-DFT front end and core.
// Holds the complex sample layout and the feeder FSM state encoding.
package dft_pkg;

  localparam int DFT_WIDTH      = 12;
  localparam int DFT_FIFO_DEPTH = 8;

  typedef struct packed {
    logic signed [DFT_WIDTH-1:0] re;
    logic signed [DFT_WIDTH-1:0] im;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } feeder_state_t;

endpackage

// File: rtl/dft_sample_fifo.sv
// Synchronous FIFO with occupancy count and a registered read port.
// rd_data only updates on a pop, so it can directly drive a held output.
module dft_sample_fifo
  import dft_pkg::*;
#(
  parameter int DATA_WIDTH = 2 * DFT_WIDTH,
  parameter int DEPTH      = DFT_FIFO_DEPTH,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A full FIFO still accepts a push when a slot frees up in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/dft_sample_feeder.sv
// Buffers complex samples and hands them one at a time to the sliding-DFT core.
// Optional input decimation is enabled by defining FEEDER_DECIM_EN.
module dft_sample_feeder
  import dft_pkg::*;
#(
  parameter int WIDTH       = DFT_WIDTH,
  parameter int FIFO_DEPTH  = DFT_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = 4096,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1,
  localparam int CW         = $clog2(TIMEOUT_CYC) + 1
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_x_re,
  input  logic signed [WIDTH-1:0] i_x_im,
  input  logic [3:0]              i_decim,
  input  logic                    i_clr_err,
  output logic signed [WIDTH-1:0] o_x [0:1],
  output logic                    o_wr,
  input  logic                    i_done,
  output logic [LW-1:0]           o_fifo_level,
  output logic                    o_busy,
  output logic                    o_overflow,
  output logic                    o_timeout
);

  feeder_state_t        state;
  feeder_state_t        next_state;
  logic                 sample_valid;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [2*WIDTH-1:0]   head;
  logic                 done_q;
  logic                 done_rise;
  logic [CW-1:0]        wait_cnt;
  logic                 timeout_evt;
  logic                 overflow_evt;

`ifdef FEEDER_DECIM_EN
  logic [3:0] decim_cnt;
  logic [3:0] decim_q;
  logic [3:0] decim_cur;

  // A new decimation factor is picked up only on the first strobe after a wrap.
  assign decim_cur    = (decim_cnt == 4'd0) ? i_decim : decim_q;
  assign sample_valid = i_valid && (decim_cnt == decim_cur);

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      decim_cnt <= '0;
      decim_q   <= '0;
    end else if (i_valid) begin
      if (decim_cnt == 4'd0) begin
        decim_q <= i_decim;
      end
      decim_cnt <= sample_valid ? 4'd0 : decim_cnt + 4'd1;
    end
  end
`else
  logic unused_decim;

  assign unused_decim = ^i_decim;
  assign sample_valid = i_valid;
`endif

  dft_sample_fifo #(
    .DATA_WIDTH (2 * WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_sys_clk),
    .rst     (i_sys_rst),
    .push    (sample_valid),
    .pop     (fifo_pop),
    .wr_data ({i_x_re, i_x_im}),
    .rd_data (head),
    .level   (o_fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_x[0]    = head[2*WIDTH-1:WIDTH];
  assign o_x[1]    = head[WIDTH-1:0];
  assign o_wr      = (state == ISSUE);
  assign o_busy    = (state != IDLE);
  assign done_rise = i_done && !done_q;

  always_comb begin
    next_state  = state;
    fifo_pop    = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (done_rise) begin
          next_state = IDLE;
        end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
          timeout_evt = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign overflow_evt = sample_valid && fifo_full && !fifo_pop;

  // wait_cnt counts cycles elapsed since the o_wr pulse; it sits at zero in ISSUE.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      wait_cnt   <= '0;
      o_overflow <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= next_state;
      done_q     <= i_done;
      wait_cnt   <= (state == IDLE) ? '0 : wait_cnt + CW'(1);
      o_overflow <= overflow_evt || (o_overflow && !i_clr_err);
      o_timeout  <= timeout_evt || (o_timeout && !i_clr_err);
    end
  end

endmodule

// File: tb/tb_dft_sample_feeder.sv
// Scoreboard bench for dft_sample_feeder with a simple core done model.
// Covers latency, streaming, overflow, timeout, reset abort and FEEDER_DECIM_EN gating.
module tb_dft_sample_feeder;
  import dft_pkg::*;

  localparam int W     = 12;
  localparam int DEPTH = 8;
  localparam int TO    = 1024;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                valid = 1'b0;
  logic                clr_err = 1'b0;
  logic                done = 1'b0;
  logic signed [W-1:0] x_re = '0;
  logic signed [W-1:0] x_im = '0;
  logic [3:0]          decim = '0;
  logic signed [W-1:0] x_out [0:1];
  logic                wr;
  logic                busy;
  logic                overflow;
  logic                timeout;
  logic [LW-1:0]       level;

  int      errors = 0;
  int      checks = 0;
  int      wr_count = 0;
  int      done_events = 0;
  int      core_lat = 600;
  bit      core_stall = 1'b0;
  bit      busy_after_done = 1'b1;
  bit      have_exp = 1'b0;
  sample_t exp_q[$];
  sample_t mon_exp;
  sample_t last_exp;

  dft_sample_feeder #(
    .WIDTH       (W),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst    (rst),
    .i_valid      (valid),
    .i_x_re       (x_re),
    .i_x_im       (x_im),
    .i_decim      (decim),
    .i_clr_err    (clr_err),
    .o_x          (x_out),
    .o_wr         (wr),
    .i_done       (done),
    .o_fifo_level (level),
    .o_busy       (busy),
    .o_overflow   (overflow),
    .o_timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint actual, input longint required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Drive one strobe for a cycle; the scoreboard learns whether it should reach the core.
  task automatic apply_stimulus(input logic signed [W-1:0] re, input logic signed [W-1:0] im,
                                input bit accept);
    valid = 1'b1;
    x_re  = re;
    x_im  = im;
    if (accept) exp_q.push_back('{re: re, im: im});
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || level != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, longint'(busy || level != '0), 0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Monitor: every write pulse must carry the next expected sample, held until the next pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wr: actual=1 required=0");
        end else begin
          mon_exp = exp_q.pop_front();
          check_output("o_x_re", x_out[0], mon_exp.re);
          check_output("o_x_im", x_out[1], mon_exp.im);
          last_exp = mon_exp;
          have_exp = 1'b1;
        end
      end else if (busy && have_exp) begin
        check_output("o_x_hold", {x_out[0], x_out[1]}, last_exp);
      end
    end
  end

  // Core model: done rises core_lat cycles after each write and stays high one cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (wr && !core_stall && !rst) begin
        repeat (core_lat) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        busy_after_done = busy;
        done_events++;
        done = 1'b0;
      end
    end
  end

  initial begin
    #700000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int n;
    int w0;
    int de;
    int max_level;
    int exp_cnt;
    logic [31:0] r;

    repeat (3) @(negedge clk);
    check_output("rst_wr", wr, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_level", level, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_timeout", timeout, 0);
    check_output("rst_x", {x_out[0], x_out[1]}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single sample latency");
    core_lat = 600;
    de = done_events;
    apply_stimulus(12'sh002, 12'sh000, 1'b1);
    valid = 1'b0;
    n = 1;
    while (!wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_output("wr_latency", n, 2);
    n = 0;
    while (done_events == de && n < 800) begin
      @(negedge clk);
      n++;
    end
    check_output("done_seen", done_events, de + 1);
    check_output("busy_after_done", busy_after_done, 0);
    wait_idle(20, "idle_t1");
    check_output("wr_count_t1", wr_count, 1);

    $display("[TB] random streaming");
    w0 = wr_count;
    max_level = 0;
    for (int i = 0; i < 32; i++) begin
      core_lat = $urandom_range(20, 60);
      r = $urandom;
      apply_stimulus(r[W-1:0], r[2*W-1:W], 1'b1);
      valid = 1'b0;
      for (int k = 0; k < 70; k++) begin
        if (int'(level) > max_level) max_level = int'(level);
        @(negedge clk);
      end
    end
    wait_idle(200, "idle_t2");
    check_output("stream_max_level", max_level, 1);
    check_output("stream_overflow", overflow, 0);
    check_output("stream_wr_count", wr_count - w0, 32);
    check_output("stream_queue_empty", exp_q.size(), 0);

    $display("[TB] burst into stalled core");
    core_stall = 1'b1;
    w0 = wr_count;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(W'((i + 1) * 3), W'(-(i + 1)), i <= DEPTH);
    end
    valid = 1'b0;
    check_output("burst_level", level, DEPTH);
    check_output("burst_overflow", overflow, 1);
    pulse_clr();
    check_output("overflow_cleared", overflow, 0);
    wait_idle(9 * (TO + 4), "idle_t3");
    check_output("burst_wr_count", wr_count - w0, DEPTH + 1);
    check_output("burst_timeout", timeout, 1);
    pulse_clr();
    check_output("timeout_cleared", timeout, 0);

    $display("[TB] timeout then next sample");
    apply_stimulus(12'sh123, -12'sh045, 1'b1);
    apply_stimulus(-12'sh7ff, 12'sh7ff, 1'b1);
    valid = 1'b0;
    n = 0;
    while (!wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_output("to_first_wr", wr, 1);
    n = 0;
    while (!timeout && n < 2 * TO) begin
      @(negedge clk);
      n++;
    end
    check_output("timeout_delay", n, TO);
    n = 0;
    while (!wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_output("next_issue_delay", n, 1);
    wait_idle(TO + 10, "idle_t4");
    pulse_clr();

    $display("[TB] reset during wait");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(W'(100 + i), W'(i), 1'b1);
    end
    valid = 1'b0;
    repeat (5) @(negedge clk);
    check_output("pre_rst_busy", busy, 1);
    check_output("pre_rst_level", level, 3);
    rst = 1'b1;
    exp_q.delete();
    have_exp = 1'b0;
    @(negedge clk);
    check_output("rst_mid_level", level, 0);
    check_output("rst_mid_wr", wr, 0);
    check_output("rst_mid_busy", busy, 0);
    check_output("rst_mid_x", {x_out[0], x_out[1]}, 0);
    rst = 1'b0;
    w0 = wr_count;
    repeat (100) @(negedge clk);
    check_output("no_wr_after_rst", wr_count - w0, 0);
    core_stall = 1'b0;

    $display("[TB] decimation gating");
    core_lat = 5;
    decim = 4'd3;
    w0 = wr_count;
    exp_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
`ifdef FEEDER_DECIM_EN
      apply_stimulus(W'(i * 7), W'(-i), (i % 4) == 0);
      if ((i % 4) == 0) exp_cnt++;
`else
      apply_stimulus(W'(i * 7), W'(-i), 1'b1);
      exp_cnt++;
`endif
      valid = 1'b0;
      repeat (20) @(negedge clk);
    end
    wait_idle(100, "idle_t6");
    check_output("decim_wr_count", wr_count - w0, exp_cnt);
    check_output("final_queue_empty", exp_q.size(), 0);
    check_output("final_overflow", overflow, 0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dft_sample_feeder.md
Name: dft_sample_feeder

Overview:
- Upstream stage of the sliding-DFT core (DFT_ff_i_q).
- Accepts complex LFP samples at the acquisition rate and buffers them in a small FIFO.
- Issues exactly one single-cycle write pulse per sample to the core, then waits for the core's done indication before issuing the next.
- Absorbs rate mismatch and reports overflow and stall conditions.

Parameters:
- WIDTH, 12, sample component width (two's complement), matches DFT core WIDTH.
- FIFO_DEPTH, 8, sample FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYC, 4096, cycles to wait for done after a write before declaring a stall.

Ports:
- i_sys_clk  in  1  system clock; all logic on the rising edge.
- i_sys_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input sample strobe, one sample per asserted cycle.
- i_x_re  in  WIDTH  real component, signed.
- i_x_im  in  WIDTH  imaginary component, signed (tie 0 for real-only LFP).
- i_decim  in  4  decimation factor minus 1; used only with FEEDER_DECIM_EN.
- i_clr_err  in  1  clears the sticky o_overflow and o_timeout flags.
- o_x  out  2 x WIDTH  unpacked [0:1] array to core i_x; [0] real, [1] imaginary.
- o_wr  out  1  single-cycle write pulse to core i_wr.
- i_done  in  1  core o_done (level).
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_busy  out  1  high when the FSM is not in IDLE.
- o_overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- o_timeout  out  1  sticky: the core did not signal done within TIMEOUT_CYC.

Behaviour:
- Reset: all outputs are 0, the FIFO is emptied, the FSM enters IDLE, and the done edge register is cleared. Reset mid-transaction aborts it and discards all buffered samples.
- FIFO push: on i_valid (after decimation gating).
  - Full with no pop in the same cycle: the sample is dropped and o_overflow is set.
  - Full with a simultaneous pop: the push is accepted and level stays at FIFO_DEPTH.
- FIFO pop: occurs only in the IDLE→ISSUE transition.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE: if level > 0, pop the head into the o_x register (1-cycle registered read) and go to ISSUE.
  - ISSUE: o_wr = 1 for exactly this one cycle; clear the timeout counter; go to WAIT_DONE.
  - WAIT_DONE:
    - A rising edge of i_done (i_done high and the previous cycle low) returns the FSM to IDLE.
    - If the counter reaches TIMEOUT_CYC-1 first, set o_timeout and return to IDLE.
    - A done level already high at entry is ignored until it falls and rises again.
- o_x holds stable from ISSUE until the next pop. It never changes while the core may still be sampling it.
- Throughput: at most one sample per (done latency + 3) cycles. Minimum spacing between o_wr pulses is 3 cycles.
- Latency: a sample pushed into an empty FIFO while in IDLE produces o_wr 2 cycles later.
- i_clr_err in the same cycle as a new overflow or timeout event: the event wins and the flag stays set.
- Sample components pass through with no arithmetic. Widths match the core.

Optional Feature:
- Macro: FEEDER_DECIM_EN.
- Defined: a 4-bit counter counts i_valid strobes. Only the strobe where the count equals i_decim is pushed, then the counter resets to 0. The counter is reset by i_sys_rst. A change to i_decim takes effect at the next counter wrap.
- Undefined: every i_valid is pushed and i_decim is ignored.

Decomposition:
- dft_pkg holds:
  - the complex sample struct typedef (re/im, WIDTH);
  - the FSM state enum (IDLE/ISSUE/WAIT_DONE);
  - the default WIDTH and FIFO_DEPTH constants shared with the DFT core.
- Sub-module dft_sample_fifo: a synchronous FIFO with push, pop, level, full and empty, and a registered read. The feeder instantiates one.

Test Plan:
- Single sample 0x002/0x000 into an idle feeder, core model asserts done 600 cycles after wr → exactly one o_wr, 2 cycles after i_valid; o_x = {0x002, 0x000} held until done; o_busy drops 1 cycle after the done edge.
- 128 samples spaced 600 cycles, core done latency 500 → 128 o_wr pulses in input order; level never exceeds 1; o_overflow = 0.
- Burst of 12 consecutive i_valid with FIFO_DEPTH = 8, core stalled → level saturates at 8, o_overflow = 1; the samples issued to the core are the first 9 (1 popped immediately plus 8 buffered); i_clr_err clears the flag.
- Core never asserts done → o_timeout = 1 exactly TIMEOUT_CYC cycles after o_wr; the next queued sample is then issued.
- i_sys_rst asserted in WAIT_DONE with 3 queued samples → next cycle level = 0, o_wr = 0, o_x = 0, FSM in IDLE; no further o_wr without new input.
- FEEDER_DECIM_EN with i_decim = 3 and 16 i_valid strobes → 4 pushes (strobes 4, 8, 12, 16).
